// File: rtl/config_regfile_if.sv
// Command/response bus between the UART command decoder and config_regfile.
// One command in flight; the response is a single-cycle strobe with no backpressure.
interface config_regfile_if #(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [IDX_W-1:0]  cmd_idx;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [2:0]        rsp_code;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_data,
    input  cmd_ready, rsp_valid, rsp_code, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_data,
    output cmd_ready, rsp_valid, rsp_code, rsp_data
  );
endinterface

// File: rtl/config_regfile.sv
// Runtime parameter bank: writes are staged in a shadow bank and applied to the
// live bank atomically on COMMIT, after a min <= max pair check.
module config_regfile #(
  parameter int NUM_PARAMS = 8,
  parameter int DATA_W     = 8,
  parameter int IDX_W      = $clog2(NUM_PARAMS),
  parameter logic [NUM_PARAMS*DATA_W-1:0] DEFAULTS =
    {8'd0, 8'd0, 8'd0, 8'd3, 8'd10, 8'd9, 8'd0, 8'd2},
  parameter logic [NUM_PARAMS*DATA_W-1:0] MINS =
    {8'd0, 8'd0, 8'd0, -8'd128, 8'd1, -8'd128, -8'd128, 8'd1},
  parameter logic [NUM_PARAMS*DATA_W-1:0] MAXS =
    {8'd255, 8'd255, 8'd255, 8'd127, 8'd99, 8'd127, 8'd127, 8'd10},
  parameter logic [NUM_PARAMS-1:0] SIGNED_MASK = 8'b0001_0110,
  parameter bit PAIR_EN     = 1'b1,
  parameter int PAIR_LO_IDX = 1,
  parameter int PAIR_HI_IDX = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  config_regfile_if.slave              bus,
  output logic [NUM_PARAMS*DATA_W-1:0] live_flat,
  output logic [NUM_PARAMS-1:0]        dirty_mask,
  output logic [NUM_PARAMS-1:0]        changed_mask
);
  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_COMMIT = 2'd2;
  localparam logic [1:0] OP_ABORT  = 2'd3;
  localparam logic [2:0] RC_OK      = 3'd0;
  localparam logic [2:0] RC_BAD_IDX = 3'd1;
  localparam logic [2:0] RC_RANGE   = 3'd2;
  localparam logic [2:0] RC_PAIR    = 3'd3;

  typedef enum logic [1:0] {IDLE, RESP, CHECK, APPLY} state_t;
  state_t state, state_nx;

  logic [NUM_PARAMS-1:0][DATA_W-1:0] live, shadow;
  logic [NUM_PARAMS-1:0] dirty, changed, rng_ok;
  logic [2**IDX_W-1:0]   idx_map;
  logic                  started, accept, idx_ok, pair_bad;
  logic [2:0]            code_q;
  logic [DATA_W-1:0]     data_q;

  // started holds cmd_ready low until the first edge after reset release
  assign bus.cmd_ready = (state == IDLE) & started;
  assign bus.rsp_valid = (state == RESP) | (state == APPLY);
  assign bus.rsp_code  = code_q;
  assign bus.rsp_data  = data_q;
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign idx_ok        = idx_map[bus.cmd_idx];
  assign live_flat     = live;
  assign dirty_mask    = dirty;
  assign changed_mask  = changed;

  for (genvar i = 0; i < 2**IDX_W; i++) begin : g_idx
    assign idx_map[i] = (i < NUM_PARAMS);
  end

  // Bounds compared on a one-bit-wider signed value so both signedness modes share one comparator
  for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_rng
    localparam logic [DATA_W-1:0] LO = MINS[i*DATA_W +: DATA_W];
    localparam logic [DATA_W-1:0] HI = MAXS[i*DATA_W +: DATA_W];
    logic [DATA_W:0] v_x, lo_x, hi_x;
    assign v_x  = {SIGNED_MASK[i] & bus.cmd_data[DATA_W-1], bus.cmd_data};
    assign lo_x = {SIGNED_MASK[i] & LO[DATA_W-1], LO};
    assign hi_x = {SIGNED_MASK[i] & HI[DATA_W-1], HI};
    assign rng_ok[i] = ($signed(v_x) >= $signed(lo_x)) && ($signed(v_x) <= $signed(hi_x));
  end

  if (PAIR_EN) begin : g_pair
    localparam bit S = SIGNED_MASK[PAIR_LO_IDX];
    logic [DATA_W:0] lo_x, hi_x;
    assign lo_x = {S & shadow[PAIR_LO_IDX][DATA_W-1], shadow[PAIR_LO_IDX]};
    assign hi_x = {S & shadow[PAIR_HI_IDX][DATA_W-1], shadow[PAIR_HI_IDX]};
    assign pair_bad = $signed(lo_x) > $signed(hi_x);
  end else begin : g_nopair
    assign pair_bad = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (bus.cmd_op == OP_COMMIT) ? CHECK : RESP;
      CHECK:   state_nx = pair_bad ? RESP : APPLY;
      default: state_nx = IDLE;
    endcase
  end

  // The live bank is loaded on the CHECK->APPLY edge so new values, changed_mask
  // and the OK strobe are all visible together during APPLY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started <= 1'b0;
      live    <= DEFAULTS;
      shadow  <= DEFAULTS;
      dirty   <= '0;
      changed <= '0;
      code_q  <= RC_OK;
      data_q  <= '0;
    end else begin
      started <= 1'b1;
      changed <= '0;
      if (accept) begin
        code_q <= RC_OK;
        data_q <= '0;
        case (bus.cmd_op)
          OP_WRITE: begin
            if (!idx_ok)                     code_q <= RC_BAD_IDX;
            else if (!rng_ok[bus.cmd_idx])   code_q <= RC_RANGE;
            else begin
              shadow[bus.cmd_idx] <= bus.cmd_data;
              dirty[bus.cmd_idx]  <= 1'b1;
            end
          end
          OP_READ: begin
            if (!idx_ok) code_q <= RC_BAD_IDX;
            else data_q <= bus.cmd_data[0] ? shadow[bus.cmd_idx] : live[bus.cmd_idx];
          end
          OP_ABORT: begin
            shadow <= live;
            dirty  <= '0;
          end
          default: ;
        endcase
      end
      if (state == CHECK) begin
        if (pair_bad) code_q <= RC_PAIR;
        else begin
          for (int i = 0; i < NUM_PARAMS; i++) begin
            if (dirty[i]) begin
              live[i]    <= shadow[i];
              changed[i] <= (shadow[i] != live[i]);
            end
          end
          dirty <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_config_regfile.sv
// Bench for config_regfile: directed scenarios then random commands, all checked
// against an integer-valued model of the parameter banks.
module tb_config_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  config_regfile_if #(.IDX_W(3), .DATA_W(8)) bus ();
  config_regfile_if #(.IDX_W(3), .DATA_W(8)) bus2 ();
  logic [63:0] live_flat;
  logic [7:0]  dirty_mask, changed_mask;
  logic [39:0] live5;
  logic [4:0]  dirty5, changed5;

  config_regfile u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .live_flat(live_flat), .dirty_mask(dirty_mask), .changed_mask(changed_mask)
  );

  config_regfile #(
    .NUM_PARAMS(5), .DATA_W(8),
    .DEFAULTS({8'd3, 8'd10, 8'd9, 8'd0, 8'd2}),
    .MINS({-8'd128, 8'd1, -8'd128, -8'd128, 8'd1}),
    .MAXS({8'd127, 8'd99, 8'd127, 8'd127, 8'd10}),
    .SIGNED_MASK(5'b10110)
  ) u_small (
    .clk(clk), .rst(rst), .bus(bus2),
    .live_flat(live5), .dirty_mask(dirty5), .changed_mask(changed5)
  );

  // Reference: parameter rules as plain integers, idx 0 first
  int MINV[8] = '{1, -128, -128, 1, -128, 0, 0, 0};
  int MAXV[8] = '{10, 127, 127, 99, 127, 255, 255, 255};
  bit SGN[8]  = '{0, 1, 1, 0, 1, 0, 0, 0};
  logic [7:0] DEFV[8] = '{8'd2, 8'd0, 8'd9, 8'd10, 8'd3, 8'd0, 8'd0, 8'd0};

  logic [7:0] live_m[8];
  logic [7:0] sh_m[8];
  logic [7:0] dirty_m;

  int tests = 0;
  int fails = 0;

  logic [2:0] r_code;
  logic [7:0] r_data, r_chg, r_chg_after;
  int         r_lat;
  logic       r_rdy, r_vld_after;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sv(input int i, input logic [7:0] v);
    return SGN[i] ? int'($signed(v)) : int'(v);
  endfunction

  function automatic logic [63:0] exp_live();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = live_m[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      live_m[i] = DEFV[i];
      sh_m[i]   = DEFV[i];
    end
    dirty_m = 8'h00;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] idx, input logic [7:0] d);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", (n < 20), 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_idx   = idx;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    r_lat = 0; r_code = 3'b111; r_data = 8'hxx; r_chg = 8'hxx; r_rdy = 1'bx;
    for (int k = 1; k <= 4 && r_lat == 0; k++) begin
      if (bus.rsp_valid === 1'b1) begin
        r_lat  = k;
        r_code = bus.rsp_code;
        r_data = bus.rsp_data;
        r_chg  = changed_mask;
        r_rdy  = bus.cmd_ready;
      end else @(negedge clk);
    end
    @(negedge clk);
    r_vld_after = bus.rsp_valid;
    r_chg_after = changed_mask;
  endtask

  task automatic run(input logic [1:0] op, input logic [2:0] idx, input logic [7:0] d);
    logic [2:0] ec;
    logic [7:0] ed, echg;
    int elat;
    ec = 3'd0; ed = 8'd0; echg = 8'd0; elat = 1;
    case (op)
      2'd0: begin
        if (sv(idx, d) < MINV[idx] || sv(idx, d) > MAXV[idx]) ec = 3'd2;
        else begin
          sh_m[idx] = d;
          dirty_m[idx] = 1'b1;
        end
      end
      2'd1: ed = d[0] ? sh_m[idx] : live_m[idx];
      2'd2: begin
        elat = 2;
        if (sv(1, sh_m[1]) > sv(1, sh_m[2])) ec = 3'd3;
        else begin
          for (int i = 0; i < 8; i++) begin
            if (dirty_m[i]) begin
              echg[i] = (sh_m[i] != live_m[i]);
              live_m[i] = sh_m[i];
            end
          end
          dirty_m = 8'h00;
        end
      end
      default: begin
        for (int i = 0; i < 8; i++) sh_m[i] = live_m[i];
        dirty_m = 8'h00;
      end
    endcase
    issue(op, idx, d);
    chk("latency", r_lat, elat);
    chk("rsp_code", r_code, ec);
    chk("rsp_data", r_data, ed);
    chk("rdy_in_rsp", r_rdy, 1'b0);
    chk("rsp_one_cycle", r_vld_after, 1'b0);
    chk("live_flat", live_flat, exp_live());
    chk("dirty_mask", dirty_mask, dirty_m);
    if (op == 2'd2) begin
      chk("changed_mask", r_chg, echg);
      chk("changed_pulse", r_chg_after, 8'h00);
    end
  endtask

  task automatic small_cmd(input logic [1:0] op, input logic [2:0] idx, input logic [7:0] d,
                           input logic [2:0] ec, input logic [7:0] ed);
    @(negedge clk);
    bus2.cmd_valid = 1'b1;
    bus2.cmd_op = op; bus2.cmd_idx = idx; bus2.cmd_data = d;
    @(negedge clk);
    bus2.cmd_valid = 1'b0;
    chk("small_rsp_valid", bus2.rsp_valid, 1'b1);
    chk("small_rsp_code", bus2.rsp_code, ec);
    chk("small_rsp_data", bus2.rsp_data, ed);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] op;
    logic [2:0] idx;
    logic [7:0] d;
    int sel;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_idx = 3'd0; bus.cmd_data = 8'd0;
    bus2.cmd_valid = 1'b0; bus2.cmd_op = 2'd0; bus2.cmd_idx = 3'd0; bus2.cmd_data = 8'd0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_code", bus.rsp_code, 3'd0);
    chk("rst_live", live_flat, 64'h0000_0003_0A09_0002);
    chk("rst_dirty", dirty_mask, 8'h00);
    chk("rst_changed", changed_mask, 8'h00);
    rst = 1'b0;
    chk("ready_at_release", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_release", bus.cmd_ready, 1'b1);

    for (int i = 0; i < 8; i++) run(2'd1, 3'(i), 8'd0);

    run(2'd0, 3'd0, 8'd5);
    run(2'd0, 3'd3, 8'd0);
    chk("w_idx3_range", r_code, 3'd2);
    run(2'd0, 3'd4, 8'h80);
    chk("dirty_11", dirty_mask, 8'h11);
    run(2'd1, 3'd4, 8'd1);
    chk("shadow_idx4", r_data, 8'h80);
    run(2'd1, 3'd4, 8'd0);
    chk("live_idx4", r_data, 8'd3);

    run(2'd2, 3'd0, 8'd0);
    chk("commit_changed", r_chg, 8'h11);
    chk("commit_live", live_flat[39:0], 40'h80_0A_09_00_05);

    run(2'd0, 3'd1, 8'd20);
    run(2'd0, 3'd2, 8'hFD);
    run(2'd2, 3'd0, 8'd0);
    chk("pair_code", r_code, 3'd3);
    chk("pair_dirty", dirty_mask, 8'h06);
    chk("pair_live12", live_flat[23:8], 16'h0900);
    run(2'd3, 3'd0, 8'd0);
    run(2'd1, 3'd1, 8'd1);
    chk("abort_shadow1", r_data, 8'd0);

    run(2'd0, 3'd3, 8'd10);
    run(2'd2, 3'd0, 8'd0);
    chk("same_val_changed", r_chg, 8'h00);
    run(2'd2, 3'd0, 8'd0);

    small_cmd(2'd0, 3'd5, 8'd1, 3'd1, 8'd0);
    small_cmd(2'd1, 3'd7, 8'd1, 3'd1, 8'd0);
    small_cmd(2'd0, 3'd4, 8'h80, 3'd0, 8'd0);
    chk("small_dirty", dirty5, 5'h10);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      idx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) d = 8'($urandom_range(0, 255));
      else d = 8'(MINV[idx] + int'($urandom_range(0, MAXV[idx] - MINV[idx])));
      run(op, idx, d);
    end

    run(2'd0, 3'd0, 8'd7);
    while (bus.cmd_ready !== 1'b1) @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_idx = 3'd0; bus.cmd_data = 8'd0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("midrst_live0", live_flat[7:0], 8'd2);
    @(negedge clk);
    chk("midrst_rsp_valid2", bus.rsp_valid, 1'b0);
    rst = 1'b0;
    chk("midrst_ready_low", bus.cmd_ready, 1'b0);
    chk("midrst_dirty", dirty_mask, 8'h00);
    @(negedge clk);
    chk("midrst_ready", bus.cmd_ready, 1'b1);
    chk("midrst_rsp_valid3", bus.rsp_valid, 1'b0);
    chk("midrst_live", live_flat, exp_live());
    run(2'd1, 3'd0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/config_regfile.md
Name: config_regfile

Overview:
- Parametrised successor to the single-register configuration manager. Holds NUM_PARAMS runtime parameters, each DATA_W bits wide, with per-parameter default, bounds and signedness.
- Writes are staged in a shadow bank. A COMMIT command applies them atomically to the live bank, after a cross-parameter (min <= max) check. ABORT discards them.
- Sits between the UART command decoder and all consumers of live parameters: generator, countdown, scalar unit.

Parameters:
- NUM_PARAMS, 8, number of parameters.
- DATA_W, 8, bits per parameter.
- IDX_W, $clog2(NUM_PARAMS), index width (derived).
- DEFAULTS, {8'd0,8'd0,8'd0,8'd3,8'd10,8'd9,8'd0,8'd2} (idx0 in LSBs), packed reset/default values.
- MINS, {8'd0,8'd0,8'd0,-8'd128,8'd1,-8'd128,-8'd128,8'd1}, packed lower bounds, inclusive.
- MAXS, {8'd255,8'd255,8'd255,8'd127,8'd99,8'd127,8'd127,8'd10}, packed upper bounds, inclusive.
- SIGNED_MASK, 8'b0001_0110, bit i=1 means parameter i is compared as two's complement.
- PAIR_EN, 1, enables the commit-time pair check.
- PAIR_LO_IDX, 1, index that must be <= PAIR_HI_IDX.
- PAIR_HI_IDX, 2, upper index of the pair.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts a command this cycle
- cmd_op  in  2  0 WRITE, 1 READ, 2 COMMIT, 3 ABORT
- cmd_idx  in  IDX_W  parameter index (WRITE/READ)
- cmd_data  in  DATA_W  write value; for READ, bit0 selects the bank (0 live, 1 shadow)
- rsp_valid  out  1  one-cycle response strobe
- rsp_code  out  3  0 OK, 1 BAD_IDX, 2 RANGE, 3 PAIR
- rsp_data  out  DATA_W  read data, 0 for non-READ
- live_flat  out  NUM_PARAMS*DATA_W  live parameter bank, broadcast to consumers
- dirty_mask  out  NUM_PARAMS  shadow entries pending commit
- changed_mask  out  NUM_PARAMS  one-cycle pulse: live entries altered by a commit

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: live = shadow = DEFAULTS; dirty_mask = 0; changed_mask = 0; rsp_valid = 0; rsp_code = 0; rsp_data = 0; cmd_ready = 0; FSM = IDLE.
  - cmd_ready rises in the first cycle after rst deasserts.
  - Reset mid-operation abandons any command; no response is issued.
- Invariant: shadow[i] == live[i] whenever dirty_mask[i] == 0.
- FSM states: IDLE, RESP, CHECK, APPLY.
  - cmd_ready = 1 only in IDLE. Accept = cmd_valid & cmd_ready.
- IDLE, WRITE accepted:
  - If idx >= NUM_PARAMS: code BAD_IDX.
  - Else if the value is outside [MIN, MAX] (signed or unsigned per SIGNED_MASK): code RANGE; shadow unchanged.
  - Else: shadow[idx] <= data, dirty[idx] <= 1, code OK.
  - Next state RESP.
  - Repeated writes to the same index: last value wins.
- IDLE, READ accepted: BAD_IDX check as for WRITE, then rsp_data = selected bank[idx]. Next state RESP.
- IDLE, ABORT accepted: shadow <= live, dirty <= 0, code OK (also OK when nothing is pending). Next state RESP.
- IDLE, COMMIT accepted: next state CHECK.
  - CHECK: if PAIR_EN and staged[LO] > staged[HI] (signedness of LO): code PAIR, shadow and dirty retained, next state RESP. Otherwise next state APPLY.
  - APPLY:
    - live <= shadow for all dirty entries.
    - changed_mask <= dirty & (shadow != live), one-cycle pulse.
    - dirty <= 0.
    - rsp_valid = 1 with code OK in the same cycle; then return to IDLE.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- Latency:
  - WRITE / READ / ABORT: rsp_valid in cycle T+1 after accept at T.
  - COMMIT: response at T+2.
  - Throughput: one command per 2 cycles; COMMIT occupies 3.
- Commit with empty dirty_mask: passes CHECK, APPLY changes nothing, changed_mask = 0, code OK.
- live_flat changes only in APPLY or reset; it never shows partially applied values.

Test Plan:
- Reset release, then READ live idx 0..7 -> DEFAULTS values returned, code 0, rsp_valid one cycle after each accept; cmd_ready low during rsp cycle.
- WRITE idx0=5, WRITE idx3=0, WRITE idx4=-128 -> codes 0, 2, 0. dirty_mask = 8'h11. live_flat unchanged. READ shadow idx4 -> 8'h80; READ live idx4 -> 3.
- COMMIT after the previous step -> rsp at T+2 code 0; changed_mask = 8'h11 for one cycle; live idx0=5, idx4=-128; dirty_mask = 0.
- WRITE idx1=20, WRITE idx2=-3, COMMIT -> code 3 (PAIR); live idx1/idx2 stay 0/9; dirty_mask = 8'h06. ABORT -> dirty 0, READ shadow idx1 -> 0.
- WRITE idx3=10 (equal to live), COMMIT -> code 0, changed_mask = 0, dirty cleared. WRITE idx 5 with NUM_PARAMS=5 build -> code 1.
- Assert rst between the COMMIT accept and APPLY with idx0 dirty -> no rsp_valid, live idx0 = 2, dirty = 0, cmd_ready = 1 one cycle after rst falls.
